// File: rtl/fpnew_normalize_pack_if.sv
// Handshake and data bundle for fpnew_normalize_pack.
// slave faces the normalizer, master faces whoever drives it.
interface fpnew_normalize_pack_if #(
  parameter int unsigned EXP_BITS  = 8,
  parameter int unsigned MAN_BITS  = 23,
  parameter int unsigned SUM_WIDTH = 52
);
  logic                          in_valid_i;
  logic                          in_ready_o;
  logic                          sign_i;
  logic signed [EXP_BITS+1:0]    exponent_i;
  logic [SUM_WIDTH-1:0]          sum_i;
  logic                          sticky_i;
  logic [2:0]                    rnd_mode_i;
  logic                          effective_subtraction_i;
  logic                          out_valid_o;
  logic                          out_ready_i;
  logic [EXP_BITS+MAN_BITS-1:0]  abs_value_o;
  logic [1:0]                    round_sticky_bits_o;
  logic                          sign_o;
  logic [2:0]                    rnd_mode_o;
  logic                          effective_subtraction_o;
  logic                          overflow_o;

  modport slave (
    input  in_valid_i,
    input  sign_i,
    input  exponent_i,
    input  sum_i,
    input  sticky_i,
    input  rnd_mode_i,
    input  effective_subtraction_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output abs_value_o,
    output round_sticky_bits_o,
    output sign_o,
    output rnd_mode_o,
    output effective_subtraction_o,
    output overflow_o
  );

  modport master (
    output in_valid_i,
    output sign_i,
    output exponent_i,
    output sum_i,
    output sticky_i,
    output rnd_mode_i,
    output effective_subtraction_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  abs_value_o,
    input  round_sticky_bits_o,
    input  sign_o,
    input  rnd_mode_o,
    input  effective_subtraction_o,
    input  overflow_o
  );
endinterface

// File: rtl/fpnew_normalize_pack.sv
// Two-stage normalize-and-pack ahead of FP rounding.
// Define FPNEW_NORM_SKID_EN for a skid buffer with a registered in_ready_o.
module fpnew_normalize_pack #(
  parameter int unsigned EXP_BITS  = 8,
  parameter int unsigned MAN_BITS  = 23,
  parameter int unsigned SUM_WIDTH = 52
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  fpnew_normalize_pack_if.slave io
);

  localparam int unsigned EW  = EXP_BITS + 3;
  localparam int unsigned LZW = $clog2(SUM_WIDTH + 1);
  localparam int unsigned AW  = EXP_BITS + MAN_BITS;

  localparam logic signed [EW-1:0] ONE_S  = EW'(1);
  localparam logic signed [EW-1:0] SW_S   = EW'(SUM_WIDTH);
  localparam logic signed [EW-1:0] EMAX_S =
    EW'((1 << EXP_BITS) - 1);
  localparam logic [SUM_WIDTH-1:0] ONES   = '1;
  localparam logic [SUM_WIDTH-1:0] LOW_MASK =
    ONES >> (MAN_BITS + 2);

  function automatic logic [LZW-1:0] lzc_f(
    input logic [SUM_WIDTH-1:0] v
  );
    lzc_f = LZW'(SUM_WIDTH);
    for (int i = 0; i < SUM_WIDTH; i++) begin
      if (v[i]) lzc_f = LZW'(SUM_WIDTH - 1 - i);
    end
  endfunction

  // ---------------- stage-1 source ----------------
  logic                       src_v;
  logic                       src_sign;
  logic signed [EXP_BITS+1:0] src_exp;
  logic [SUM_WIDTH-1:0]       src_sum;
  logic                       src_sticky;
  logic [2:0]                 src_rnd;
  logic                       src_eff;

  logic s1_v_q, s1_v_d;
  logic s2_v_q, s2_v_d;
  logic s1_ready;
  logic s2_ready;

  assign s2_ready = !s2_v_q || io.out_ready_i;
  assign s1_ready = !s1_v_q || s2_ready;

`ifdef FPNEW_NORM_SKID_EN
  logic                       skid_v_q, skid_v_d;
  logic                       skid_sign_q, skid_sign_d;
  logic signed [EXP_BITS+1:0] skid_exp_q, skid_exp_d;
  logic [SUM_WIDTH-1:0]       skid_sum_q, skid_sum_d;
  logic                       skid_sticky_q, skid_sticky_d;
  logic [2:0]                 skid_rnd_q, skid_rnd_d;
  logic                       skid_eff_q, skid_eff_d;

  // Parked item always has priority so ordering is kept.
  always_comb begin
    skid_v_d      = skid_v_q;
    skid_sign_d   = skid_sign_q;
    skid_exp_d    = skid_exp_q;
    skid_sum_d    = skid_sum_q;
    skid_sticky_d = skid_sticky_q;
    skid_rnd_d    = skid_rnd_q;
    skid_eff_d    = skid_eff_q;
    if (skid_v_q) begin
      skid_v_d = !s1_ready;
    end else if (io.in_valid_i && !s1_ready) begin
      skid_v_d      = 1'b1;
      skid_sign_d   = io.sign_i;
      skid_exp_d    = io.exponent_i;
      skid_sum_d    = io.sum_i;
      skid_sticky_d = io.sticky_i;
      skid_rnd_d    = io.rnd_mode_i;
      skid_eff_d    = io.effective_subtraction_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_v_q      <= 1'b0;
      skid_sign_q   <= 1'b0;
      skid_exp_q    <= '0;
      skid_sum_q    <= '0;
      skid_sticky_q <= 1'b0;
      skid_rnd_q    <= '0;
      skid_eff_q    <= 1'b0;
    end else begin
      skid_v_q      <= skid_v_d;
      skid_sign_q   <= skid_sign_d;
      skid_exp_q    <= skid_exp_d;
      skid_sum_q    <= skid_sum_d;
      skid_sticky_q <= skid_sticky_d;
      skid_rnd_q    <= skid_rnd_d;
      skid_eff_q    <= skid_eff_d;
    end
  end

  assign io.in_ready_o = !skid_v_q;
  assign src_v      = skid_v_q || io.in_valid_i;
  assign src_sign   = skid_v_q ? skid_sign_q   : io.sign_i;
  assign src_exp    = skid_v_q ? skid_exp_q    : io.exponent_i;
  assign src_sum    = skid_v_q ? skid_sum_q    : io.sum_i;
  assign src_sticky = skid_v_q ? skid_sticky_q : io.sticky_i;
  assign src_rnd    = skid_v_q ? skid_rnd_q    : io.rnd_mode_i;
  assign src_eff    = skid_v_q ? skid_eff_q
                               : io.effective_subtraction_i;
`else
  assign io.in_ready_o = s1_ready;
  assign src_v      = io.in_valid_i;
  assign src_sign   = io.sign_i;
  assign src_exp    = io.exponent_i;
  assign src_sum    = io.sum_i;
  assign src_sticky = io.sticky_i;
  assign src_rnd    = io.rnd_mode_i;
  assign src_eff    = io.effective_subtraction_i;
`endif

  // ---------------- stage 1 ----------------
  logic                       s1_sign_q, s1_sign_d;
  logic signed [EXP_BITS+1:0] s1_exp_q, s1_exp_d;
  logic [SUM_WIDTH-1:0]       s1_sum_q, s1_sum_d;
  logic                       s1_sticky_q, s1_sticky_d;
  logic [2:0]                 s1_rnd_q, s1_rnd_d;
  logic                       s1_eff_q, s1_eff_d;
  logic [LZW-1:0]             s1_lzc_q, s1_lzc_d;

  always_comb begin
    s1_v_d      = s1_v_q;
    s1_sign_d   = s1_sign_q;
    s1_exp_d    = s1_exp_q;
    s1_sum_d    = s1_sum_q;
    s1_sticky_d = s1_sticky_q;
    s1_rnd_d    = s1_rnd_q;
    s1_eff_d    = s1_eff_q;
    s1_lzc_d    = s1_lzc_q;
    if (s1_ready) begin
      s1_v_d = src_v;
      if (src_v) begin
        s1_sign_d   = src_sign;
        s1_exp_d    = src_exp;
        s1_sum_d    = src_sum;
        s1_sticky_d = src_sticky;
        s1_rnd_d    = src_rnd;
        s1_eff_d    = src_eff;
        s1_lzc_d    = lzc_f(src_sum);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_v_q      <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_sum_q    <= '0;
      s1_sticky_q <= 1'b0;
      s1_rnd_q    <= '0;
      s1_eff_q    <= 1'b0;
      s1_lzc_q    <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_sign_q   <= s1_sign_d;
      s1_exp_q    <= s1_exp_d;
      s1_sum_q    <= s1_sum_d;
      s1_sticky_q <= s1_sticky_d;
      s1_rnd_q    <= s1_rnd_d;
      s1_eff_q    <= s1_eff_d;
      s1_lzc_q    <= s1_lzc_d;
    end
  end

  // ---------------- normalize ----------------
  logic signed [EW-1:0] exp_w;
  logic signed [EW-1:0] lzc_w;
  logic signed [EW-1:0] shl;
  logic signed [EW-1:0] shr;
  logic signed [EW-1:0] res_exp;
  logic [SUM_WIDTH-1:0] shifted;
  logic                 lost;
  logic [AW-1:0]        abs_n;
  logic [1:0]           rs_n;
  logic                 ovf_n;

  always_comb begin
    exp_w   = EW'(s1_exp_q);
    lzc_w   = EW'(s1_lzc_q);
    shl     = '0;
    shr     = '0;
    res_exp = '0;
    shifted = s1_sum_q;
    lost    = 1'b0;
    abs_n   = '0;
    rs_n    = '0;
    ovf_n   = 1'b0;
    if (exp_w >= ONE_S) begin
      shl = (lzc_w < exp_w - ONE_S) ? lzc_w
                                     : exp_w - ONE_S;
      shifted = s1_sum_q << shl;
      res_exp = exp_w - shl;
    end else begin
      shr = ONE_S - exp_w;
      if (shr > SW_S) shr = SW_S;
      shifted = s1_sum_q >> shr;
      lost = |(s1_sum_q & ~(ONES << shr));
    end
    if (s1_sum_q == '0) begin
      rs_n = {1'b0, s1_sticky_q};
    end else if (res_exp >= EMAX_S) begin
      abs_n = {{EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
      ovf_n = 1'b1;
    end else begin
      // Hidden bit still clear after a capped shift: subnormal.
      abs_n[AW-1:MAN_BITS] = shifted[SUM_WIDTH-1]
                           ? res_exp[EXP_BITS-1:0]
                           : '0;
      abs_n[MAN_BITS-1:0] = shifted[SUM_WIDTH-2 -: MAN_BITS];
      rs_n = {shifted[SUM_WIDTH-2-MAN_BITS],
              (|(shifted & LOW_MASK)) | lost | s1_sticky_q};
    end
  end

  // ---------------- stage 2 ----------------
  logic [AW-1:0] abs_q, abs_d;
  logic [1:0]    rs_q, rs_d;
  logic          ovf_q, ovf_d;
  logic          sign_q, sign_d;
  logic [2:0]    rnd_q, rnd_d;
  logic          eff_q, eff_d;

  always_comb begin
    s2_v_d = s2_v_q;
    abs_d  = abs_q;
    rs_d   = rs_q;
    ovf_d  = ovf_q;
    sign_d = sign_q;
    rnd_d  = rnd_q;
    eff_d  = eff_q;
    if (s2_ready) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        abs_d  = abs_n;
        rs_d   = rs_n;
        ovf_d  = ovf_n;
        sign_d = s1_sign_q;
        rnd_d  = s1_rnd_q;
        eff_d  = s1_eff_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_v_q <= 1'b0;
      abs_q  <= '0;
      rs_q   <= '0;
      ovf_q  <= 1'b0;
      sign_q <= 1'b0;
      rnd_q  <= '0;
      eff_q  <= 1'b0;
    end else begin
      s2_v_q <= s2_v_d;
      abs_q  <= abs_d;
      rs_q   <= rs_d;
      ovf_q  <= ovf_d;
      sign_q <= sign_d;
      rnd_q  <= rnd_d;
      eff_q  <= eff_d;
    end
  end

  assign io.out_valid_o              = s2_v_q;
  assign io.abs_value_o              = abs_q;
  assign io.round_sticky_bits_o      = rs_q;
  assign io.overflow_o               = ovf_q;
  assign io.sign_o                   = sign_q;
  assign io.rnd_mode_o               = rnd_q;
  assign io.effective_subtraction_o  = eff_q;

endmodule

// File: tb/tb_fpnew_normalize_pack.sv
// Directed bench for fpnew_normalize_pack (default parameters).
// Honours FPNEW_NORM_SKID_EN for the back-pressure acceptance count.
module tb_fpnew_normalize_pack;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fpnew_normalize_pack_if bus();

  fpnew_normalize_pack dut (
    .clk_i (clk),
    .rst_i (rst),
    .io    (bus)
  );

  always #5 clk = ~clk;

  logic [30:0] r_abs;
  logic [1:0]  r_rs;
  logic        r_ovf;
  logic        r_sign;
  logic [2:0]  r_rnd;
  logic        r_eff;
  int          r_lat;

  localparam logic [51:0] B51 = 52'h8_0000_0000_0000;
  localparam logic [51:0] B49 = 52'h2_0000_0000_0000;
  localparam logic [51:0] B25 = 52'h0_0000_0200_0000;

`ifdef FPNEW_NORM_SKID_EN
  localparam int EXP_ACC = 3;
`else
  localparam int EXP_ACC = 2;
`endif

  task automatic run_item(
    input logic              sg,
    input logic signed [9:0] e,
    input logic [51:0]       s,
    input logic              st,
    input logic [2:0]        rm,
    input logic              es
  );
    int n;
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    bus.in_valid_i = 1'b1;
    bus.sign_i = sg;
    bus.exponent_i = e;
    bus.sum_i = s;
    bus.sticky_i = st;
    bus.rnd_mode_i = rm;
    bus.effective_subtraction_i = es;
    n = 0;
    while (!bus.in_ready_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.in_valid_i = 1'b0;
    r_lat = 1;
    @(negedge clk);
    while (!bus.out_valid_o && r_lat < 8) begin
      @(posedge clk);
      r_lat++;
      @(negedge clk);
    end
    r_abs  = bus.abs_value_o;
    r_rs   = bus.round_sticky_bits_o;
    r_ovf  = bus.overflow_o;
    r_sign = bus.sign_o;
    r_rnd  = bus.rnd_mode_o;
    r_eff  = bus.effective_subtraction_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.sign_i = 1'b0;
    bus.exponent_i = '0;
    bus.sum_i = '0;
    bus.sticky_i = 1'b0;
    bus.rnd_mode_i = '0;
    bus.effective_subtraction_i = 1'b0;
    #3;
    checks++;
    if (bus.out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", bus.out_valid_o);
    end
    checks++;
    if (bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready_o);
    end
    checks++;
    if (bus.abs_value_o !== 31'h0 ||
        bus.round_sticky_bits_o !== 2'b00 ||
        bus.overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got %h/%b/%b want 0/00/0",
               bus.abs_value_o, bus.round_sticky_bits_o,
               bus.overflow_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_normal();
    run_item(1'b1, 10'sd127, B51, 1'b0, 3'd5, 1'b1);
    checks++;
    if (r_abs !== 31'h3F800000) begin
      errors++;
      $display("FAIL normal_abs got %h want 3f800000", r_abs);
    end
    checks++;
    if (r_rs !== 2'b00 || r_ovf !== 1'b0) begin
      errors++;
      $display("FAIL normal_rs_ovf got %b/%b want 00/0", r_rs, r_ovf);
    end
    checks++;
    if (r_lat !== 2) begin
      errors++;
      $display("FAIL normal_latency got %0d want 2", r_lat);
    end
    checks++;
    if (r_sign !== 1'b1 || r_rnd !== 3'd5 || r_eff !== 1'b1) begin
      errors++;
      $display("FAIL normal_sideband got %b/%0d/%b want 1/5/1",
               r_sign, r_rnd, r_eff);
    end
  endtask

  task automatic test_round();
    run_item(1'b0, 10'sd129, B49 | B25, 1'b0, 3'd0, 1'b0);
    checks++;
    if (r_abs !== 31'h3F800000 || r_rs !== 2'b10) begin
      errors++;
      $display("FAIL round_r got %h/%b want 3f800000/10", r_abs, r_rs);
    end
    checks++;
    if (r_sign !== 1'b0 || r_rnd !== 3'd0 || r_eff !== 1'b0) begin
      errors++;
      $display("FAIL round_sideband got %b/%0d/%b want 0/0/0",
               r_sign, r_rnd, r_eff);
    end
    run_item(1'b0, 10'sd129, B49 | B25, 1'b1, 3'd2, 1'b0);
    checks++;
    if (r_abs !== 31'h3F800000 || r_rs !== 2'b11) begin
      errors++;
      $display("FAIL round_rs got %h/%b want 3f800000/11", r_abs, r_rs);
    end
  endtask

  task automatic test_subnormal();
    run_item(1'b0, 10'sd1, B49, 1'b0, 3'd1, 1'b0);
    checks++;
    if (r_abs !== 31'h00200000 || r_rs !== 2'b00) begin
      errors++;
      $display("FAIL sub_e1 got %h/%b want 00200000/00", r_abs, r_rs);
    end
    run_item(1'b0, -10'sd1, B49, 1'b0, 3'd1, 1'b0);
    checks++;
    if (r_abs !== 31'h00080000 || r_rs !== 2'b00) begin
      errors++;
      $display("FAIL sub_em1 got %h/%b want 00080000/00", r_abs, r_rs);
    end
    run_item(1'b0, -10'sd1, B49 | 52'h1, 1'b0, 3'd1, 1'b0);
    checks++;
    if (r_abs !== 31'h00080000 || r_rs !== 2'b01) begin
      errors++;
      $display("FAIL sub_lost got %h/%b want 00080000/01", r_abs, r_rs);
    end
    run_item(1'b0, 10'sd2, B49, 1'b0, 3'd1, 1'b0);
    checks++;
    if (r_abs !== 31'h00400000 || r_rs !== 2'b00) begin
      errors++;
      $display("FAIL sub_capped got %h/%b want 00400000/00", r_abs, r_rs);
    end
  endtask

  task automatic test_overflow_zero();
    run_item(1'b0, 10'sd255, B51, 1'b0, 3'd0, 1'b0);
    checks++;
    if (r_abs !== 31'h7F800000 || r_ovf !== 1'b1 || r_rs !== 2'b00) begin
      errors++;
      $display("FAIL ovf got %h/%b/%b want 7f800000/1/00",
               r_abs, r_ovf, r_rs);
    end
    run_item(1'b0, 10'sd254, B51, 1'b0, 3'd0, 1'b0);
    checks++;
    if (r_abs !== 31'h7F000000 || r_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_edge got %h/%b want 7f000000/0", r_abs, r_ovf);
    end
    run_item(1'b0, 10'sd100, 52'h0, 1'b1, 3'd0, 1'b0);
    checks++;
    if (r_abs !== 31'h0 || r_rs !== 2'b01 || r_ovf !== 1'b0) begin
      errors++;
      $display("FAIL zero got %h/%b/%b want 0/01/0", r_abs, r_rs, r_ovf);
    end
  endtask

  task automatic test_backpressure();
    int k;
    int idx;
    int hold_bad;
    logic [30:0] held;
    logic seen;
    logic acc;
    k = 0;
    hold_bad = 0;
    seen = 1'b0;
    held = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.out_valid_o) begin
        if (!seen) held = bus.abs_value_o;
        else if (bus.abs_value_o !== held) hold_bad++;
        seen = 1'b1;
      end else if (seen) begin
        hold_bad++;
      end
      bus.out_ready_i = 1'b0;
      bus.in_valid_i = 1'b1;
      bus.sign_i = 1'b0;
      bus.exponent_i = 10'(100 + k);
      bus.sum_i = B51;
      bus.sticky_i = 1'b0;
      acc = bus.in_ready_o;
      @(posedge clk);
      if (acc) k++;
    end
    checks++;
    if (k !== EXP_ACC) begin
      errors++;
      $display("FAIL bp_accepted got %0d want %0d", k, EXP_ACC);
    end
    checks++;
    if (hold_bad !== 0 || !seen) begin
      errors++;
      $display("FAIL bp_stable got %0d changes seen=%b want 0/1",
               hold_bad, seen);
    end
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.out_valid_o) begin
        checks++;
        if (bus.abs_value_o !== 31'((100 + idx) << 23)) begin
          errors++;
          $display("FAIL bp_order item %0d got %h want %h", idx,
                   bus.abs_value_o, 31'((100 + idx) << 23));
        end
        idx++;
      end
      @(posedge clk);
    end
    checks++;
    if (idx !== k) begin
      errors++;
      $display("FAIL bp_drain got %0d items want %0d", idx, k);
    end
  endtask

  task automatic test_reset_flush();
    int stale;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.exponent_i = 10'sd50;
    bus.sum_i = B51;
    @(negedge clk);
    bus.exponent_i = 10'sd51;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_async got valid=%b ready=%b want 0/1",
               bus.out_valid_o, bus.in_ready_o);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready_i = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid_o) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL flush_stale got %0d valid cycles want 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_round();
    test_subnormal();
    test_overflow_zero();
    test_backpressure();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpnew_normalize_pack.md
FPNEW_NORMALIZE_PACK -- requirements
Module: fpnew_normalize_pack

Interface
REQ-001 Parameter EXP_BITS, default 8, exponent field width.
REQ-002 Parameter MAN_BITS, default 23, stored mantissa width (hidden bit excluded).
REQ-003 Parameter SUM_WIDTH, default 52, unnormalized magnitude width; SHALL be >= MAN_BITS+3.
REQ-004 clk_i  in  1  single clock, rising edge.
REQ-005 rst_i  in  1  asynchronous reset, active-high.
REQ-006 in_valid_i / in_ready_o  in/out  1/1  input handshake.
REQ-007 sign_i  in  1  result sign.
REQ-008 exponent_i  in  EXP_BITS+2  signed biased exponent of bit SUM_WIDTH-1 of sum_i.
REQ-009 sum_i  in  SUM_WIDTH  unsigned unnormalized magnitude.
REQ-010 sticky_i  in  1  OR of bits lost in upstream alignment.
REQ-011 rnd_mode_i / effective_subtraction_i  in  3/1  sideband, passed through unchanged.
REQ-012 out_valid_o / out_ready_i  out/in  1/1  output handshake.
REQ-013 abs_value_o  out  EXP_BITS+MAN_BITS  packed {exponent, mantissa}, ready for rounding.
REQ-014 round_sticky_bits_o  out  2  {round, sticky}.
REQ-015 sign_o, rnd_mode_o, effective_subtraction_o  out  1/3/1  registered sideband.
REQ-016 overflow_o  out  1  exponent saturated, abs_value_o carries infinity encoding.

Function
REQ-017 Two-stage pipeline: stage 1 registers inputs plus leading-zero count (lzc) of sum_i; stage 2 registers shifted, packed result; latency exactly 2 cycles with no stalls.
REQ-018 Transfer occurs when valid and ready are both high on a rising edge; a stage loads when empty or when its contents leave in the same cycle.
REQ-019 Once out_valid_o is high, it and all outputs SHALL hold stable until out_ready_i is high.
REQ-020 exponent_i >= 1: left shift = min(lzc, exponent_i-1); result exponent = exponent_i - shift; exponent field 0 if bit SUM_WIDTH-1 is 0 after the shift.
REQ-021 exponent_i <= 0: right shift = min(1-exponent_i, SUM_WIDTH); shifted-out bits ORed into sticky; exponent field 0.
REQ-022 After the shift: mantissa = bits [SUM_WIDTH-2 : SUM_WIDTH-1-MAN_BITS]; round = next lower bit; sticky = OR of all lower bits, right-shift losses, and sticky_i.
REQ-023 sum_i == 0: abs_value_o = 0, round_sticky_bits_o = {0, sticky_i}, overflow_o = 0.
REQ-024 Result exponent >= 2^EXP_BITS-1: exponent field all ones, mantissa 0, round_sticky_bits_o = 00, overflow_o = 1.
REQ-025 All exponent arithmetic in signed EXP_BITS+3 bits; no wrap-around.

Reset
REQ-026 rst_i high SHALL immediately clear both stage valid flags; out_valid_o = 0, in_ready_o = 1, all data outputs 0.
REQ-027 Reset asserted mid-operation discards in-flight items; nothing in flight reappears after release.

Configuration
REQ-028 Macro FPNEW_NORM_SKID_EN defined: a one-entry skid buffer sits in front of stage 1; in_ready_o driven directly from a flop (no combinational path from out_ready_i), deasserting only when the skid buffer is occupied.
REQ-029 FPNEW_NORM_SKID_EN undefined: no skid buffer; in_ready_o = !stage1_valid || stage-1 advancing, combinational from out_ready_i.
REQ-030 Latency, data results and ordering SHALL be identical in both configurations.

Verification
REQ-031 sum_i = bit51 only, exponent_i = 127, out_ready_i = 1 -> after 2 cycles abs_value_o = 0x3F800000, RS = 00, overflow_o = 0.
REQ-032 sum_i = bit49 | bit25, exponent_i = 129 -> abs_value_o = 0x3F800000, RS = 10; with sticky_i = 1 -> RS = 11.
REQ-033 sum_i = bit49, exponent_i = 1 -> abs_value_o = 0x00200000 (subnormal), RS = 00; exponent_i = -1 -> abs_value_o = 0x00080000.
REQ-034 sum_i = bit51, exponent_i = 255 -> abs_value_o = 0x7F800000, overflow_o = 1, RS = 00; sum_i = 0, sticky_i = 1 -> abs_value_o = 0, RS = 01.
REQ-035 out_ready_i = 0 for 6 cycles, in_valid_i held high with distinct items -> exactly 2 accepted (3 with FPNEW_NORM_SKID_EN), outputs stable, all items emerge in order once out_ready_i = 1.
REQ-036 rst_i pulsed while 2 items in flight -> out_valid_o = 0 within the reset cycle, no stale item emitted after release.
